// File: rtl/pwm_breath.sv
// -----------------------------------------------------------------------------
// pwm_breath
//   PWM generator with a fixed-duty mode and a "breathing" mode. In breathing
//   mode the duty ramps up by STEP every period until the output is fully on,
//   then ramps back down to fully off, and repeats. New period/duty/mode
//   values are staged in a pending register and only take effect at a period
//   boundary, or on the next edge while the block is disabled. This keeps
//   every running period glitch-free.
//
// Parameters
//   CNT_WIDTH : width of the period counter and the period/duty values
//   STEP      : breathing duty increment/decrement per period
//               (expected to be in the range 1 .. 2**CNT_WIDTH)
//
// Ports
//   clk_in_i     : clock; all logic runs on its rising edge
//   rst_n_i      : asynchronous active-low reset
//   tick_i       : count enable pulse from the upstream divider
//   en_i         : run enable; low clears the counter, output and ramp
//   mode_i       : 0 = fixed duty, 1 = breathing (captured by load_i)
//   period_i     : period minus one, in ticks (captured by load_i)
//   duty_i       : high time in ticks for fixed mode (captured by load_i)
//   load_i       : one-cycle strobe capturing period_i/duty_i/mode_i
//   pwm_o        : registered PWM output
//   period_end_o : one-cycle pulse on the edge where the counter wraps
//   load_ack_o   : one-cycle pulse on the edge where staged values go live
//   dbg_state_o  : breathing FSM state (0 = IDLE, 1 = UP, 2 = DOWN)
// -----------------------------------------------------------------------------
module pwm_breath #(
  parameter int CNT_WIDTH = 8,
  parameter int STEP      = 1
) (
  input  logic                 clk_in_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  input  logic [CNT_WIDTH-1:0] duty_i,
  input  logic                 load_i,
  output logic                 pwm_o,
  output logic                 period_end_o,
  output logic                 load_ack_o,
  output logic [1:0]           dbg_state_o
);

  // Effective duty needs one extra bit so it can hold period+1 (fully on).
  localparam int DW = CNT_WIDTH + 1;

  localparam logic [DW-1:0] STEP_D   = DW'(STEP);
  localparam logic [DW:0]   STEP_SUM = (DW + 1)'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  // Configuration handshake: load_i is a single-cycle strobe with no
  // back-pressure; it is always accepted and overwrites anything still
  // pending. load_ack_o pulses for exactly one cycle on the edge where a
  // pending configuration becomes active, so a burst of loads between two
  // boundaries yields a single acknowledge for the last one.

  // Staged configuration
  logic [CNT_WIDTH-1:0] pend_period_q, pend_period_d;
  logic [CNT_WIDTH-1:0] pend_duty_q,   pend_duty_d;
  logic                 pend_mode_q,   pend_mode_d;
  logic                 pend_q,        pend_d;

  // Active configuration
  logic [CNT_WIDTH-1:0] act_period_q,  act_period_d;
  logic [CNT_WIDTH-1:0] act_duty_q,    act_duty_d;
  logic                 act_mode_q,    act_mode_d;

  // Running state
  logic [CNT_WIDTH-1:0] cnt_q,         cnt_d;
  logic [DW-1:0]        bduty_q,       bduty_d;
  state_e               state_q,       state_d;
  logic                 pwm_q,         pwm_d;
  logic                 period_end_q,  period_end_d;
  logic                 load_ack_q,    load_ack_d;

  logic                 boundary;
  logic                 apply;
  logic [DW-1:0]        period_p1;
  logic [DW:0]          bduty_sum;
  logic [DW-1:0]        eff_duty;

  always_comb begin
    boundary = tick_i & en_i & (cnt_q == act_period_q);
    // A load arriving on this same edge is not part of "pending" yet, so a
    // coincident boundary applies the older value and the new one waits.
    apply    = pend_q & (boundary | ~en_i);

    act_period_d = apply ? pend_period_q : act_period_q;
    act_duty_d   = apply ? pend_duty_q   : act_duty_q;
    act_mode_d   = apply ? pend_mode_q   : act_mode_q;
    load_ack_d   = apply;

    pend_period_d = load_i ? period_i : pend_period_q;
    pend_duty_d   = load_i ? duty_i   : pend_duty_q;
    pend_mode_d   = load_i ? mode_i   : pend_mode_q;
    pend_d        = load_i | (pend_q & ~apply);

    // Ramp limits follow the period that governs the coming period.
    period_p1 = {1'b0, act_period_d} + DW'(1);
    bduty_sum = {1'b0, bduty_q} + STEP_SUM;

    cnt_d        = cnt_q;
    bduty_d      = bduty_q;
    state_d      = state_q;
    pwm_d        = pwm_q;
    period_end_d = 1'b0;
    eff_duty     = '0;

    if (!en_i) begin
      cnt_d   = '0;
      pwm_d   = 1'b0;
      state_d = ST_IDLE;
      bduty_d = '0;
    end else if (tick_i) begin
      period_end_d = boundary;
      cnt_d        = boundary ? '0 : cnt_q + CNT_WIDTH'(1);

      if (!act_mode_d) begin
        // Fixed mode (including a 1->0 switch at this boundary).
        state_d = ST_IDLE;
        bduty_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_UP;
            bduty_d = '0;
          end
          ST_UP: begin
            if (boundary) begin
              if (bduty_sum >= {1'b0, period_p1}) begin
                bduty_d = period_p1;
                state_d = ST_DOWN;
              end else begin
                bduty_d = bduty_sum[DW-1:0];
              end
            end
          end
          ST_DOWN: begin
            if (boundary) begin
              if (bduty_q <= STEP_D) begin
                bduty_d = '0;
                state_d = ST_UP;
              end else begin
                bduty_d = bduty_q - STEP_D;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            bduty_d = '0;
          end
        endcase
      end

      // Compare against the counter and duty of the coming cycle so the
      // output has no extra latency relative to the counter.
      eff_duty = act_mode_d ? bduty_d : {1'b0, act_duty_d};
      pwm_d    = ({1'b0, cnt_d} < eff_duty);
    end
  end

  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_mode_q   <= 1'b0;
      pend_q        <= 1'b0;
      act_period_q  <= '1;
      act_duty_q    <= '0;
      act_mode_q    <= 1'b0;
      cnt_q         <= '0;
      bduty_q       <= '0;
      state_q       <= ST_IDLE;
      pwm_q         <= 1'b0;
      period_end_q  <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_mode_q   <= pend_mode_d;
      pend_q        <= pend_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      act_mode_q    <= act_mode_d;
      cnt_q         <= cnt_d;
      bduty_q       <= bduty_d;
      state_q       <= state_d;
      pwm_q         <= pwm_d;
      period_end_q  <= period_end_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign pwm_o        = pwm_q;
  assign period_end_o = period_end_q;
  assign load_ack_o   = load_ack_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pwm_breath.sv
// -----------------------------------------------------------------------------
// tb_pwm_breath
//   Self-checking bench for pwm_breath. A behavioural model tracks the
//   expected outputs every cycle; a table of fixed configurations checks
//   high-time / wrap / acknowledge counts, and hand-written sequences cover
//   the breathing ramp, mid-period reload, slow ticks and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pwm_breath;

  localparam int W    = 8;
  localparam int STEP = 1;
  localparam int OW   = 5;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         tick  = 1'b0;
  logic         en    = 1'b0;
  logic         mode  = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] duty   = '0;
  logic         pwm, pe, ack;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {state, ack, period_end, pwm} for the next edge.
  logic [OW-1:0] exp_q[$];

  // Reference model state (plain integers)
  int m_cnt, m_per, m_duty, m_pend, p_per, p_duty;
  bit m_mode, p_mode;
  int m_phase;   // 0 idle, 1 rising, 2 falling
  int m_bd;
  bit m_pwm, m_pe, m_ack;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  pwm_breath #(.CNT_WIDTH(W), .STEP(STEP)) dut (
    .clk_in_i     (clk),
    .rst_n_i      (rst_n),
    .tick_i       (tick),
    .en_i         (en),
    .mode_i       (mode),
    .period_i     (period),
    .duty_i       (duty),
    .load_i       (load),
    .pwm_o        (pwm),
    .period_end_o (pe),
    .load_ack_o   (ack),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------- model
  function automatic void model_reset();
    m_cnt = 0; m_per = 255; m_duty = 0; m_mode = 0;
    m_pend = 0; p_per = 0; p_duty = 0; p_mode = 0;
    m_phase = 0; m_bd = 0; m_pwm = 0; m_pe = 0; m_ack = 0;
  endfunction

  function automatic void model_step();
    bit bnd, app;
    bnd = tick && en && (m_cnt == m_per);
    app = (m_pend != 0) && (bnd || !en);
    m_ack = app;
    if (app) begin
      m_per = p_per; m_duty = p_duty; m_mode = p_mode; m_pend = 0;
    end
    if (load) begin
      p_per = int'(period); p_duty = int'(duty); p_mode = mode; m_pend = 1;
    end
    m_pe = 0;
    if (!en) begin
      m_cnt = 0; m_pwm = 0; m_phase = 0; m_bd = 0;
    end else if (tick) begin
      m_pe  = bnd;
      m_cnt = bnd ? 0 : m_cnt + 1;
      if (!m_mode) begin
        m_phase = 0; m_bd = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (bnd && m_phase == 1) begin
        m_bd = (m_bd + STEP > m_per + 1) ? m_per + 1 : m_bd + STEP;
        if (m_bd == m_per + 1) m_phase = 2;
      end else if (bnd && m_phase == 2) begin
        m_bd = (m_bd - STEP < 0) ? 0 : m_bd - STEP;
        if (m_bd == 0) m_phase = 1;
      end
      m_pwm = m_cnt < (m_mode ? m_bd : m_duty);
    end
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance model, push expectation, clock DUT, compare.
  task automatic step(input string tag);
    logic [OW-1:0] e;
    model_step();
    exp_q.push_back({2'(m_phase), m_ack, m_pe, m_pwm});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_pwm"},   pwm,       e[0]);
    check({tag, "_pe"},    pe,        e[1]);
    check({tag, "_ack"},   ack,       e[2]);
    check({tag, "_state"}, dbg_state, e[4:3]);
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; load = 1'b0; mode = 1'b0;
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_pe", pe, 0);
    check("rst_ack", ack, 0);
    check("rst_state", dbg_state, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Stage and apply a configuration while disabled; returns acks seen.
  task automatic load_cfg(input int per, input int dty, input bit md, output int acks);
    acks = 0;
    en = 1'b0; tick = 1'b1;
    load = 1'b1; period = W'(per); duty = W'(dty); mode = md;
    step("ld");
    acks += int'(ack);
    load = 1'b0;
    step("ld");
    acks += int'(ack);
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    int per;
    int duty;
    bit mode;
    int n;
    int exp_high;
    int exp_pe;
    int exp_ack;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    int acks, highs, pes, found, wait_n;
    int exp_bd[10];

    tbl[0] = '{per:9, duty:3,  mode:0, n:40, exp_high:12, exp_pe:4,  exp_ack:1};
    tbl[1] = '{per:9, duty:0,  mode:0, n:20, exp_high:0,  exp_pe:2,  exp_ack:1};
    tbl[2] = '{per:9, duty:10, mode:0, n:20, exp_high:20, exp_pe:2,  exp_ack:1};
    tbl[3] = '{per:0, duty:1,  mode:0, n:10, exp_high:10, exp_pe:10, exp_ack:1};
    tbl[4] = '{per:4, duty:2,  mode:0, n:25, exp_high:10, exp_pe:5,  exp_ack:1};
    tbl[5] = '{per:3, duty:0,  mode:1, n:35, exp_high:16, exp_pe:8,  exp_ack:1};

    #1;
    do_reset();

    // Fixed and breathing configurations from a clean start.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      load_cfg(tbl[r].per, tbl[r].duty, tbl[r].mode, acks);
      en = 1'b1; tick = 1'b1;
      highs = 0; pes = 0;
      for (int k = 0; k < tbl[r].n; k++) begin
        step("tbl");
        highs += int'(pwm);
        pes   += int'(pe);
        acks  += int'(ack);
      end
      check($sformatf("tbl%0d_high", r), highs, tbl[r].exp_high);
      check($sformatf("tbl%0d_pe", r),   pes,   tbl[r].exp_pe);
      check($sformatf("tbl%0d_ack", r),  acks,  tbl[r].exp_ack);
    end

    // Breathing ramp, period 3: per-period high time and FSM turn points.
    exp_bd = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    do_reset();
    load_cfg(3, 0, 1'b1, acks);
    en = 1'b1; tick = 1'b1;
    for (int p = 0; p < 10; p++) begin
      highs = 0;
      for (int k = 0; k < ((p == 0) ? 3 : 4); k++) begin
        step("brth");
        highs += int'(pwm);
        if (k == 0 && p == 4) check("brth_turn_down", dbg_state, 2);
        if (k == 0 && p == 8) check("brth_turn_up", dbg_state, 1);
      end
      check($sformatf("brth_p%0d_high", p), highs, exp_bd[p]);
    end

    // Mid-period reload: old duty finishes, ack coincides with the wrap.
    do_reset();
    load_cfg(9, 3, 1'b0, acks);
    en = 1'b1; tick = 1'b1;
    for (int k = 0; k < 15; k++) step("mid");
    load = 1'b1; period = 8'd9; duty = 8'd7; mode = 1'b0;
    step("mid");
    load = 1'b0;
    check("mid_no_early_ack", ack, 0);
    found = 0; wait_n = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step("mid");
      wait_n++;
      if (ack) begin
        found = 1;
        check("mid_ack_with_pe", pe, 1);
      end
    end
    check("mid_ack_seen", found, 1);
    check("mid_ack_delay", wait_n, 4);
    highs = 0; acks = 0;
    for (int k = 0; k < 10; k++) begin
      step("mid");
      highs += int'(pwm);
      acks  += int'(ack);
    end
    check("mid_new_high", highs, 7);
    check("mid_single_ack", acks, 0);

    // Tick every 4th cycle: period 3 / duty 2 stretches to 16 cycles.
    do_reset();
    load_cfg(3, 2, 1'b0, acks);
    en = 1'b1;
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      tick = (i % 4 == 0);
      step("slow");
      highs += int'(pwm);
    end
    check("slow_high", highs, 32);

    // Reset between clock edges mid-period, then enabled with no load.
    do_reset();
    load_cfg(9, 3, 1'b0, acks);
    en = 1'b1; tick = 1'b1;
    for (int k = 0; k < 12; k++) step("arst");
    check("arst_pre_high", pwm, 1);
    #3;
    do_reset();
    en = 1'b1; tick = 1'b1;
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      step("post_rst");
      highs += int'(pwm);
    end
    check("post_rst_low", highs, 0);

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en     = ($urandom_range(0, 15) != 0);
      tick   = ($urandom_range(0, 2) != 0);
      load   = ($urandom_range(0, 19) == 0);
      period = W'($urandom_range(0, 6));
      duty   = W'($urandom_range(0, 8));
      mode   = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
